// File: rtl/issue_pkg.sv
// Shared types and constants for the issue sequencer slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: state enum, lane widths, lane indices, bundle struct, saturating increment helper.
package issue_pkg;

    localparam int DMA_W   = 22;
    localparam int ARITH_W = 1;
    localparam int CACHE_W = 17;
    localparam int PERF_W  = 16;

    localparam int LANE_DMA   = 0;
    localparam int LANE_ARITH = 1;
    localparam int LANE_CACHE = 2;
    localparam int NUM_LANES  = 3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        ISSUE,
        DONE
    } state_t;

    // One queue read: the three instruction slots side by side.
    typedef struct packed {
        logic [CACHE_W-1:0] cache;
        logic [ARITH_W-1:0] arith;
        logic [DMA_W-1:0]   dma;
    } bundle_t;

    // Counter step that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/issue_lane.sv
// One dispatch slot: holds a bundle instruction and its pending bit, offers it over valid/ready.
// Latency: valid rises the cycle after load (if the active bit is set), drops the cycle after handshake.
// Backpressure: valid and instr hold while ready is low; ready without valid has no effect.
// Ports: clk, reset (sync, active-high), load/load_instr (capture), ready (in),
//        valid/instr (out), still_pending (valid held but not accepted this cycle).
module issue_lane #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_instr,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] instr,
    output logic         still_pending
);

    logic pending;
    logic fire;

    assign fire          = pending & ready;
    assign valid         = pending;
    assign still_pending = pending & ~ready;

    // The MSB of every lane instruction is its active bit; an inactive
    // slot loads but never raises valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            instr   <= '0;
        end else if (load) begin
            instr   <= load_instr;
            pending <= load_instr[W-1];
        end else if (fire) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/issue_sequencer.sv
// Lockstep issue controller: pops instruction bundles and dispatches each active slot to its unit.
// Latency: 3 cycles per bundle minimum (READ, LATCH, ISSUE), 2 for a bundle with no active slot.
// Backpressure: a lane holding ready low keeps the FSM in ISSUE; other lanes still complete.
// Ports: clk, reset (sync, active-high), start/busy/done control, q_re/q_empty/q_*_instr queue side,
//        {dma,arith,cache}_{valid,ready,instr} unit side.
// Optional: define ISSUE_SEQ_PERF_EN to add perf_bundles / perf_stall saturating counters.
module issue_sequencer
    import issue_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               q_re,
    input  logic               q_empty,
    input  logic [DMA_W-1:0]   q_dma_instr,
    input  logic [ARITH_W-1:0] q_arith_instr,
    input  logic [CACHE_W-1:0] q_cache_instr,
    output logic               dma_valid,
    input  logic               dma_ready,
    output logic [DMA_W-1:0]   dma_instr,
    output logic               arith_valid,
    input  logic               arith_ready,
    output logic [ARITH_W-1:0] arith_instr,
    output logic               cache_valid,
    input  logic               cache_ready,
    output logic [CACHE_W-1:0] cache_instr
`ifdef ISSUE_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0]  perf_bundles,
    output logic [PERF_W-1:0]  perf_stall
`endif
);

    state_t               state_q;
    state_t               state_d;
    logic                 load;
    logic                 retire;
    logic                 start_ok;
    logic [NUM_LANES-1:0] stall_mask;
    logic [NUM_LANES-1:0] q_active;
    bundle_t              q_bundle;

    assign q_bundle = '{cache: q_cache_instr, arith: q_arith_instr, dma: q_dma_instr};

    assign q_active[LANE_DMA]   = q_bundle.dma[DMA_W-1];
    assign q_active[LANE_ARITH] = q_bundle.arith[ARITH_W-1];
    assign q_active[LANE_CACHE] = q_bundle.cache[CACHE_W-1];

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        retire   = 1'b0;
        start_ok = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = READ;
                    start_ok = 1'b1;
                end
            end
            // q_re was decided on entry to READ; reuse it so the read
            // strobe and the branch can never disagree.
            READ: begin
                state_d = q_re ? LATCH : DONE;
            end
            LATCH: begin
                load = 1'b1;
                if (|q_active) begin
                    state_d = ISSUE;
                end else begin
                    state_d = READ;
                    retire  = 1'b1;
                end
            end
            ISSUE: begin
                // Leave once no lane is still waiting after this edge.
                if (~|stall_mask) begin
                    state_d = READ;
                    retire  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // q_re is registered: q_empty is sampled the cycle before READ. This is
    // safe because this block is the only reader, so the queue can only go
    // from empty to non-empty in between, never the other way.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_re    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_re    <= (state_d == READ) && !q_empty;
            busy    <= state_d inside {READ, LATCH, ISSUE};
            done    <= (state_d == DONE);
        end
    end

    issue_lane #(.W(DMA_W)) u_lane_dma (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .load_instr    (q_bundle.dma),
        .ready         (dma_ready),
        .valid         (dma_valid),
        .instr         (dma_instr),
        .still_pending (stall_mask[LANE_DMA])
    );

    issue_lane #(.W(ARITH_W)) u_lane_arith (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .load_instr    (q_bundle.arith),
        .ready         (arith_ready),
        .valid         (arith_valid),
        .instr         (arith_instr),
        .still_pending (stall_mask[LANE_ARITH])
    );

    issue_lane #(.W(CACHE_W)) u_lane_cache (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .load_instr    (q_bundle.cache),
        .ready         (cache_ready),
        .valid         (cache_valid),
        .instr         (cache_instr),
        .still_pending (stall_mask[LANE_CACHE])
    );

`ifdef ISSUE_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            perf_bundles <= '0;
            perf_stall   <= '0;
        end else begin
            if (retire) begin
                perf_bundles <= sat_inc(perf_bundles);
            end
            if ((state_q == ISSUE) && (|stall_mask)) begin
                perf_stall <= sat_inc(perf_stall);
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_sequencer.sv
// Self-checking bench for issue_sequencer: table-loaded queue model, per-lane scoreboard,
// hand-written sequences for stall, staggered multi-lane, empty start and mid-issue reset.
module tb_issue_sequencer;
    import issue_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               busy;
    logic               done;
    logic               q_re;
    logic               q_empty;
    logic [DMA_W-1:0]   q_dma_instr   = '0;
    logic [ARITH_W-1:0] q_arith_instr = '0;
    logic [CACHE_W-1:0] q_cache_instr = '0;
    logic               dma_valid, dma_ready;
    logic [DMA_W-1:0]   dma_instr;
    logic               arith_valid, arith_ready;
    logic [ARITH_W-1:0] arith_instr;
    logic               cache_valid, cache_ready;
    logic [CACHE_W-1:0] cache_instr;
`ifdef ISSUE_SEQ_PERF_EN
    logic [PERF_W-1:0]  perf_bundles;
    logic [PERF_W-1:0]  perf_stall;
`endif

    always #5 clk = ~clk;

    issue_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .q_re          (q_re),
        .q_empty       (q_empty),
        .q_dma_instr   (q_dma_instr),
        .q_arith_instr (q_arith_instr),
        .q_cache_instr (q_cache_instr),
        .dma_valid     (dma_valid),
        .dma_ready     (dma_ready),
        .dma_instr     (dma_instr),
        .arith_valid   (arith_valid),
        .arith_ready   (arith_ready),
        .arith_instr   (arith_instr),
        .cache_valid   (cache_valid),
        .cache_ready   (cache_ready),
        .cache_instr   (cache_instr)
`ifdef ISSUE_SEQ_PERF_EN
        ,
        .perf_bundles  (perf_bundles),
        .perf_stall    (perf_stall)
`endif
    );

    // ---------------- queue model (registered output, one entry per q_re) ----------------
    logic [DMA_W-1:0]   m_dma   [32];
    logic [ARITH_W-1:0] m_arith [32];
    logic [CACHE_W-1:0] m_cache [32];
    int                 q_cnt    = 0;
    int                 rd_ptr   = 0;
    logic               bad_read = 1'b0;

    assign q_empty = (rd_ptr >= q_cnt);

    always @(posedge clk) begin
        if (q_re) begin
            if (rd_ptr >= q_cnt) begin
                bad_read <= 1'b1;
            end else begin
                q_dma_instr   <= m_dma[rd_ptr];
                q_arith_instr <= m_arith[rd_ptr];
                q_cache_instr <= m_cache[rd_ptr];
                rd_ptr        <= rd_ptr + 1;
            end
        end
    end

    // ---------------- stimulus tables ----------------
    typedef struct {
        logic [DMA_W-1:0]   dma;
        logic [ARITH_W-1:0] arith;
        logic [CACHE_W-1:0] cache;
        logic [2:0]         mask;   // expected dispatches, bit order {cache, arith, dma}
    } vec_t;

    vec_t       relu_tab [7];
    vec_t       bp_tab   [7];
    vec_t       ml_vec;
    vec_t       rst_tab  [2];
    logic [2:0] ml_exp   [6];

    // ---------------- scoreboard / counters ----------------
    logic [DMA_W-1:0]   exp_dma   [$];
    logic [ARITH_W-1:0] exp_arith [$];
    logic [CACHE_W-1:0] exp_cache [$];
    int n_cmp  = 0;
    int n_fail = 0;
    int hs_dma, hs_arith, hs_cache, n_qre, n_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_vec(input vec_t v);
        m_dma[q_cnt]   = v.dma;
        m_arith[q_cnt] = v.arith;
        m_cache[q_cnt] = v.cache;
        q_cnt++;
        if (v.mask[LANE_DMA])   exp_dma.push_back(v.dma);
        if (v.mask[LANE_ARITH]) exp_arith.push_back(v.arith);
        if (v.mask[LANE_CACHE]) exp_cache.push_back(v.cache);
    endtask

    task automatic clear_counts();
        hs_dma = 0; hs_arith = 0; hs_cache = 0; n_qre = 0; n_busy = 0;
    endtask

    // Handshakes are sampled on the falling edge, where inputs and outputs are both settled.
    task automatic sample_lanes();
        if (q_re) n_qre++;
        if (busy) n_busy++;
        if (dma_valid && dma_ready) begin
            hs_dma++;
            if (exp_dma.size() == 0) check("sb_dma_unexpected", 32'(dma_instr), 32'hFFFF_FFFF);
            else                     check("sb_dma", 32'(dma_instr), 32'(exp_dma.pop_front()));
        end
        if (arith_valid && arith_ready) begin
            hs_arith++;
            if (exp_arith.size() == 0) check("sb_arith_unexpected", 32'(arith_instr), 32'hFFFF_FFFF);
            else                       check("sb_arith", 32'(arith_instr), 32'(exp_arith.pop_front()));
        end
        if (cache_valid && cache_ready) begin
            hs_cache++;
            if (exp_cache.size() == 0) check("sb_cache_unexpected", 32'(cache_instr), 32'hFFFF_FFFF);
            else                       check("sb_cache", 32'(cache_instr), 32'(exp_cache.pop_front()));
        end
    endtask

    // One clock: sample at the falling edge, return 1 time unit after the rising edge.
    task automatic cyc();
        @(negedge clk);
        sample_lanes();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_to_done(input string name);
        int n = 0;
        while (!done && n < 300) begin
            cyc();
            n++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_sb_empty(input string name);
        check({name, "_sb_dma_left"},   exp_dma.size(),   0);
        check({name, "_sb_arith_left"}, exp_arith.size(), 0);
        check({name, "_sb_cache_left"}, exp_cache.size(), 0);
    endtask

    initial begin
        logic [CACHE_W-1:0] discard;
        logic [DMA_W-1:0]   held;
        int                 n;

        relu_tab[0] = '{22'h20_0101, 1'b0, 17'h0_1000, 3'b001};
        relu_tab[1] = '{22'h00_0ABC, 1'b0, 17'h1_1000, 3'b100};
        relu_tab[2] = '{22'h00_0000, 1'b1, 17'h0_0000, 3'b010};
        relu_tab[3] = '{22'h00_0000, 1'b0, 17'h1_0002, 3'b100};
        relu_tab[4] = '{22'h20_0004, 1'b0, 17'h0_0000, 3'b001};
        relu_tab[5] = '{22'h3F_FFFF, 1'b0, 17'h0_0000, 3'b001};
        relu_tab[6] = '{22'h20_0000, 1'b0, 17'h0_0000, 3'b001};

        bp_tab[0] = '{22'h2A_5A5A, 1'b0, 17'h0_0000, 3'b001};
        bp_tab[1] = '{22'h1F_FFFF, 1'b0, 17'h0_FFFF, 3'b000};
        bp_tab[2] = '{22'h00_0000, 1'b0, 17'h1_ABCD, 3'b100};
        bp_tab[3] = '{22'h00_0000, 1'b0, 17'h0_0000, 3'b000};
        bp_tab[4] = '{22'h00_0000, 1'b1, 17'h0_0000, 3'b010};
        bp_tab[5] = '{22'h00_0001, 1'b0, 17'h0_0000, 3'b000};
        bp_tab[6] = '{22'h20_0007, 1'b0, 17'h1_0001, 3'b101};

        ml_vec = '{22'h21_2345, 1'b1, 17'h1_5555, 3'b111};
        // {cache, arith, dma} valids per ISSUE cycle with readies at 0/2/4
        ml_exp = '{3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000};

        rst_tab[0] = '{22'h00_0000, 1'b0, 17'h1_0F0F, 3'b100};
        rst_tab[1] = '{22'h20_BEEF, 1'b0, 17'h0_0000, 3'b001};

        // ---------------- reset state ----------------
        reset = 1'b1; start = 1'b0;
        dma_ready = 1'b0; arith_ready = 1'b0; cache_ready = 1'b0;
        clear_counts();
        cyc(); cyc(); cyc();
        check("rst_q_re",        32'(q_re),        0);
        check("rst_busy",        32'(busy),        0);
        check("rst_done",        32'(done),        0);
        check("rst_dma_valid",   32'(dma_valid),   0);
        check("rst_arith_valid", 32'(arith_valid), 0);
        check("rst_cache_valid", 32'(cache_valid), 0);
        check("rst_dma_instr",   32'(dma_instr),   0);
        check("rst_arith_instr", 32'(arith_instr), 0);
        check("rst_cache_instr", 32'(cache_instr), 0);
        reset = 1'b0;
        cyc();

        // ---------------- empty queue at start: IDLE -> READ -> DONE ----------------
        clear_counts();
        pulse_start();
        check("empty_read_busy", 32'(busy), 1);
        check("empty_read_done", 32'(done), 0);
        check("empty_read_q_re", 32'(q_re), 0);
        cyc();
        check("empty_done",      32'(done), 1);
        check("empty_busy",      32'(busy), 0);
        check("empty_q_re_cnt",  n_qre,     0);

        // ---------------- relu program, all readies high ----------------
        for (int i = 0; i < 7; i++) push_vec(relu_tab[i]);
        clear_counts();
        dma_ready = 1'b1; arith_ready = 1'b1; cache_ready = 1'b1;
        pulse_start();
        run_to_done("relu");
        check("relu_q_re_pulses", n_qre,    7);
        check("relu_busy_cycles", n_busy,   22);   // 7 bundles x 3 + final empty READ
        check("relu_dma_hs",      hs_dma,   4);
        check("relu_arith_hs",    hs_arith, 1);
        check("relu_cache_hs",    hs_cache, 2);
        check_sb_empty("relu");
`ifdef ISSUE_SEQ_PERF_EN
        check("relu_perf_bundles", 32'(perf_bundles), 7);
        check("relu_perf_stall",   32'(perf_stall),   0);
`endif

        // ---------------- backpressure: dma_ready low for 5 cycles on bundle 0 ----------------
        for (int i = 0; i < 7; i++) push_vec(bp_tab[i]);
        clear_counts();
        dma_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!dma_valid && n < 20) begin cyc(); n++; end
        check("bp_valid_seen", 32'(dma_valid), 1);
        held = dma_instr;
        check("bp_instr", 32'(held), 32'(bp_tab[0].dma));
        for (int i = 0; i < 5; i++) begin
            check("bp_stall_valid", 32'(dma_valid), 1);
            check("bp_stall_instr", 32'(dma_instr), 32'(held));
            check("bp_stall_q_re",  32'(q_re),      0);
            cyc();
        end
        check("bp_accept_valid", 32'(dma_valid), 1);
        check("bp_accept_instr", 32'(dma_instr), 32'(held));
        check("bp_accept_q_re",  32'(q_re),      0);
        dma_ready = 1'b1;
        cyc();
        check("bp_after_valid",  32'(dma_valid), 0);
        check("bp_after_q_re",   32'(q_re),      1);
        run_to_done("bp");
        check("bp_q_re_pulses",  n_qre,  7);
        check("bp_busy_cycles",  n_busy, 24);   // 4x3 + 3x2 + final READ + 5 stall cycles
        check_sb_empty("bp");
`ifdef ISSUE_SEQ_PERF_EN
        check("bp_perf_bundles", 32'(perf_bundles), 7);
        check("bp_perf_stall",   32'(perf_stall),   5);
`endif

        // ---------------- multi-lane bundle, readies staggered 0/2/4 ----------------
        push_vec(ml_vec);
        clear_counts();
        dma_ready = 1'b1; arith_ready = 1'b0; cache_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!dma_valid && n < 20) begin cyc(); n++; end
        check("ml_valid_seen", 32'(dma_valid), 1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("ml_valids_k%0d", k), 32'({cache_valid, arith_valid, dma_valid}), 32'(ml_exp[k]));
            if (k == 2) arith_ready = 1'b1;
            if (k == 4) cache_ready = 1'b1;
            if (k == 5) begin
                check("ml_retire_busy", 32'(busy), 1);
                check("ml_retire_q_re", 32'(q_re), 0);
            end
            cyc();
        end
        check("ml_done", 32'(done), 1);
        check_sb_empty("ml");

        // ---------------- reset in ISSUE with cache_valid high ----------------
        for (int i = 0; i < 2; i++) push_vec(rst_tab[i]);
        clear_counts();
        cache_ready = 1'b0; dma_ready = 1'b1; arith_ready = 1'b1;
        pulse_start();
        n = 0;
        while (!cache_valid && n < 20) begin cyc(); n++; end
        check("rst_mid_cache_valid", 32'(cache_valid), 1);
        reset = 1'b1;
        cyc();
        check("rst_mid_dma_valid",   32'(dma_valid),   0);
        check("rst_mid_arith_valid", 32'(arith_valid), 0);
        check("rst_mid_cache_valid0",32'(cache_valid), 0);
        check("rst_mid_busy",        32'(busy),        0);
        check("rst_mid_done",        32'(done),        0);
        reset = 1'b0;
        // the partially issued bundle is dropped, not replayed
        discard = exp_cache.pop_front();
        cache_ready = 1'b1;
        cyc();
        check("rst_mid_idle_busy", 32'(busy), 0);
        clear_counts();
        pulse_start();
        run_to_done("rst_mid");
        check("rst_mid_dma_hs",   hs_dma,   1);
        check("rst_mid_cache_hs", hs_cache, 0);
        check("rst_mid_q_re",     n_qre,    1);
        check_sb_empty("rst_mid");

        check("no_empty_read", 32'(bad_read), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
